card_dealer: RTL and testbench
==============================

# card_dealer

Round sequencer that writes the card arrays of `SM_if` which the hand-value calculator reads. It takes cards from an upstream card source over a valid/ready handshake and deals the opening P,D,P,D sequence. It then serves player hit/stand requests and draws for the dealer while the dealer total is below 17. The registered player/dealer totals from the calculator are fed back to it for bust and stop decisions.

## Interface
- `STOP_AT`, 17: dealer stands when `total_dealer_value >= STOP_AT`.
- `MAX_CARDS`, 9: slots per hand; must match `SM_if` array depth.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse: begin new round; honoured only in IDLE or DONE.
- `hit`  in  1  one-cycle pulse: player requests a card; honoured only in PLAYER.
- `stand`  in  1  one-cycle pulse: player ends turn; honoured only in PLAYER; `hit` wins if both high.
- `card_in`  in  4  card code from source: 1=Ace, 2..10, 11..13=J/Q/K.
- `card_valid`  in  1  `card_in` valid.
- `card_ready`  out  1  dealer accepts a card this cycle.
- `total_players_value`  in  5  registered player total from calculator.
- `total_dealer_value`  in  5  registered dealer total from calculator.
- `card_if`  SM_if.out  —  drives `player_card_values[0:8]` and `dealer_card_values[0:8]`, 4 bits each, 0 = empty slot.
- `player_cnt`, `dealer_cnt`  out  4  cards currently held, 0..9.
- `player_turn`  out  1  high in PLAYER state.
- `busy`  out  1  high in every state except IDLE and DONE.
- `player_bust`, `dealer_bust`  out  1  sticky until next `start` or reset.
- `round_done`  out  1  one-cycle pulse on entry to DONE.

## Operation
- States are IDLE, DEAL, PLAYER, P_DRAW, P_SETTLE, P_CHECK, D_SETTLE, D_CHECK, D_DRAW and DONE.
- Reset and `start` both clear all 18 slots to 0, clear both counts, and clear both bust flags.
- Reset goes to IDLE. `start` goes to DEAL.
- **DEAL:** accepts 4 cards in order: player slot0, dealer slot0, player slot1, dealer slot1. Then goes to PLAYER.
- **PLAYER:**
  - `hit` with `player_cnt < MAX_CARDS` → P_DRAW.
  - `stand`, or `hit` with 9 cards → D_SETTLE.
- **P_DRAW:** accepts 1 card into `player_card_values[player_cnt]` and increments `player_cnt`. → P_SETTLE.
- **P_SETTLE:** one cycle. → P_CHECK.
- **P_CHECK:**
  - `total_players_value > 21` → set `player_bust`, go to DONE (dealer does not draw).
  - Otherwise → PLAYER.
- **D_SETTLE:** one cycle. → D_CHECK.
- **D_CHECK:**
  - `total_dealer_value >= STOP_AT` → DONE; set `dealer_bust` if the total is > 21.
  - `dealer_cnt == MAX_CARDS` → DONE.
  - Otherwise → D_DRAW.
- **D_DRAW:** accepts 1 card into the next dealer slot. → D_SETTLE.
- **DONE:** holds all arrays, counts and flags until `start`.
- **Card acceptance rules:**
  - `card_ready` is high exactly in DEAL, P_DRAW and D_DRAW.
  - A transfer occurs when `card_valid && card_ready` at a rising edge.
  - A transferred code of 0, 14 or 15 is consumed and discarded: no slot write, no count change, state unchanged.
- Slots at index ≥ count always read 0. Counts saturate at 9.

## Timing
- A card is written at edge E. The calculator registers the new total at edge E+1. The CHECK state samples it in the cycle after E+1, which is why each SETTLE state is exactly one cycle.
- Minimum latencies, with `card_valid` held high:
  - `start` → PLAYER in 5 cycles.
  - `hit` → `player_turn` high again in 4 cycles.
  - Each dealer draw: 3 cycles, D_DRAW → D_SETTLE → D_CHECK.
- `round_done` is high for the first DONE cycle only.
- `start` in DONE clears everything on the same edge that enters DEAL.
- `hit`, `stand` or `start` outside their honoured states are ignored, not queued.
- `rst` asserted mid-round clears every output asynchronously: arrays, counts, flags and `card_ready` go to 0; `busy` = 0.
- `card_valid` low stalls any draw state indefinitely with no side effects.

## Test plan
- Reset, then `start` with the card stream 5,9,6,10 → P slots 5,6; D slots 9,10; `player_cnt` = `dealer_cnt` = 2; `player_turn` high 5 cycles after `start`.
- Opening deal 10,7,6,10, then `hit` with card 8 → P = 10,6,8; total 24 → `player_bust` = 1; `round_done` pulses; `dealer_cnt` stays 2.
- Deal 10,6,9,5, then `stand` with stream 4,7 → dealer takes 4 (total 15), then 7 (total 22) → `dealer_bust` = 1, `dealer_cnt` = 4.
- During DEAL, feed codes 0,14,15 before 2,3,4,5 → invalid codes produce no writes; slots end P = 2,4 and D = 3,5.
- Deliver 9 single-value cards to the player via hits (Ace = 1 counted low) → a further `hit` goes to D_SETTLE and `player_cnt` stays 9.
- Assert `rst` low in D_DRAW with `card_valid` held → all slots 0, `busy` = 0, `card_ready` = 0 immediately; after release, IDLE ignores `hit`.

Source files
------------

// File: rtl/card_dealer_if.sv
// Card-slot bundle shared between the round sequencer and the hand-value calculator.
// Each slot holds a 4-bit card code. A value of 0 marks an empty slot.
interface SM_if #(
    parameter int N = 9
);
    logic [3:0] player_card_values [0:N-1];
    logic [3:0] dealer_card_values [0:N-1];

    modport out (output player_card_values, output dealer_card_values);
    modport in  (input  player_card_values, input  dealer_card_values);
endinterface

// File: rtl/card_dealer.sv
// card_dealer: blackjack round sequencer.
// It deals P,D,P,D from a valid/ready card source, serves player hit/stand
// requests, and draws for the dealer until the calculator total reaches
// STOP_AT. The totals come back from the calculator as registered values.
// That latency is why each CHECK state sits behind a one-cycle SETTLE state.
module card_dealer #(
    parameter int STOP_AT   = 17,
    parameter int MAX_CARDS = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hit,
    input  logic       stand,
    input  logic [3:0] card_in,
    input  logic       card_valid,
    output logic       card_ready,
    input  logic [4:0] total_players_value,
    input  logic [4:0] total_dealer_value,
    SM_if.out          card_if,
    output logic [3:0] player_cnt,
    output logic [3:0] dealer_cnt,
    output logic       player_turn,
    output logic       busy,
    output logic       player_bust,
    output logic       dealer_bust,
    output logic       round_done
);

    localparam logic [3:0] MAX_V      = 4'(MAX_CARDS);
    localparam logic [4:0] STOP_V     = 5'(STOP_AT);
    localparam logic [4:0] BUST_LIMIT = 5'd21;

    typedef enum logic [3:0] {
        S_IDLE,
        S_DEAL,
        S_PLAYER,
        S_P_DRAW,
        S_P_SETTLE,
        S_P_CHECK,
        S_D_SETTLE,
        S_D_CHECK,
        S_D_DRAW,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] p_slot_q [0:MAX_CARDS-1];
    logic [3:0] p_slot_d [0:MAX_CARDS-1];
    logic [3:0] d_slot_q [0:MAX_CARDS-1];
    logic [3:0] d_slot_d [0:MAX_CARDS-1];
    logic [3:0] player_cnt_q, player_cnt_d;
    logic [3:0] dealer_cnt_q, dealer_cnt_d;
    logic       player_bust_q, player_bust_d;
    logic       dealer_bust_q, dealer_bust_d;
    logic       round_done_q, round_done_d;

    // Per-cycle strobes used inside the next-state logic.
    logic       code_ok;
    logic       card_take;
    logic       p_wr;
    logic       d_wr;

    // Codes 0, 14 and 15 are still handshaken, but they are thrown away.
    assign code_ok    = (card_in >= 4'd1) && (card_in <= 4'd13);
    assign card_ready = (state_q == S_DEAL) || (state_q == S_P_DRAW) || (state_q == S_D_DRAW);
    assign card_take  = card_valid && card_ready && code_ok;

    // Next-state, slot-write and flag logic for the round sequencer.
    always_comb begin
        state_d       = state_q;
        p_slot_d      = p_slot_q;
        d_slot_d      = d_slot_q;
        player_cnt_d  = player_cnt_q;
        dealer_cnt_d  = dealer_cnt_q;
        player_bust_d = player_bust_q;
        dealer_bust_d = dealer_bust_q;
        p_wr          = 1'b0;
        d_wr          = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_DEAL;
                    for (int i = 0; i < MAX_CARDS; i++) begin
                        p_slot_d[i] = 4'd0;
                        d_slot_d[i] = 4'd0;
                    end
                    player_cnt_d  = 4'd0;
                    dealer_cnt_d  = 4'd0;
                    player_bust_d = 1'b0;
                    dealer_bust_d = 1'b0;
                end
            end
            S_DEAL: begin
                // When the counts are equal the player is owed the next card.
                // Otherwise the dealer is owed it.
                if (card_take) begin
                    if (player_cnt_q == dealer_cnt_q) begin
                        p_wr = 1'b1;
                    end else begin
                        d_wr = 1'b1;
                        if (dealer_cnt_q == 4'd1) begin
                            state_d = S_PLAYER;
                        end
                    end
                end
            end
            S_PLAYER: begin
                if (hit) begin
                    state_d = (player_cnt_q < MAX_V) ? S_P_DRAW : S_D_SETTLE;
                end else if (stand) begin
                    state_d = S_D_SETTLE;
                end
            end
            S_P_DRAW: begin
                if (card_take) begin
                    p_wr    = 1'b1;
                    state_d = S_P_SETTLE;
                end
            end
            S_P_SETTLE: state_d = S_P_CHECK;
            S_P_CHECK: begin
                if (total_players_value > BUST_LIMIT) begin
                    player_bust_d = 1'b1;
                    state_d       = S_DONE;
                end else begin
                    state_d = S_PLAYER;
                end
            end
            S_D_SETTLE: state_d = S_D_CHECK;
            S_D_CHECK: begin
                if (total_dealer_value >= STOP_V) begin
                    state_d = S_DONE;
                    if (total_dealer_value > BUST_LIMIT) begin
                        dealer_bust_d = 1'b1;
                    end
                end else if (dealer_cnt_q >= MAX_V) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_D_DRAW;
                end
            end
            S_D_DRAW: begin
                if (card_take) begin
                    d_wr    = 1'b1;
                    state_d = S_D_SETTLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Write into the slot indexed by the current count.
        // A full hand has no matching slot, so both the slot write and the count saturate.
        for (int i = 0; i < MAX_CARDS; i++) begin
            if (p_wr && (player_cnt_q == 4'(i))) begin
                p_slot_d[i] = card_in;
            end
            if (d_wr && (dealer_cnt_q == 4'(i))) begin
                d_slot_d[i] = card_in;
            end
        end
        if (p_wr && (player_cnt_q < MAX_V)) begin
            player_cnt_d = player_cnt_q + 4'd1;
        end
        if (d_wr && (dealer_cnt_q < MAX_V)) begin
            dealer_cnt_d = dealer_cnt_q + 4'd1;
        end

        round_done_d = (state_d == S_DONE) && (state_q != S_DONE);
    end

    // State, slot and flag registers. The active-low reset clears everything immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            for (int i = 0; i < MAX_CARDS; i++) begin
                p_slot_q[i] <= 4'd0;
                d_slot_q[i] <= 4'd0;
            end
            player_cnt_q  <= 4'd0;
            dealer_cnt_q  <= 4'd0;
            player_bust_q <= 1'b0;
            dealer_bust_q <= 1'b0;
            round_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            p_slot_q      <= p_slot_d;
            d_slot_q      <= d_slot_d;
            player_cnt_q  <= player_cnt_d;
            dealer_cnt_q  <= dealer_cnt_d;
            player_bust_q <= player_bust_d;
            dealer_bust_q <= dealer_bust_d;
            round_done_q  <= round_done_d;
        end
    end

    // Expose the slot registers to the calculator through the interface.
    generate
        for (genvar gi = 0; gi < MAX_CARDS; gi++) begin : g_slot
            assign card_if.player_card_values[gi] = p_slot_q[gi];
            assign card_if.dealer_card_values[gi] = d_slot_q[gi];
        end
    endgenerate

    assign player_cnt  = player_cnt_q;
    assign dealer_cnt  = dealer_cnt_q;
    assign player_turn = (state_q == S_PLAYER);
    assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign player_bust = player_bust_q;
    assign dealer_bust = dealer_bust_q;
    assign round_done  = round_done_q;

endmodule

// File: tb/tb_card_dealer.sv
// Testbench for card_dealer.
// It models the card source and the registered hand-value calculator.
// Expected values are queued on a scoreboard and compared at observation points.
module tb_card_dealer;

    localparam int SEL_P     = 0;
    localparam int SEL_D     = 1;
    localparam int SEL_PCNT  = 2;
    localparam int SEL_DCNT  = 3;
    localparam int SEL_PBUST = 4;
    localparam int SEL_DBUST = 5;
    localparam int SEL_BUSY  = 6;
    localparam int SEL_READY = 7;
    localparam int SEL_TURN  = 8;
    localparam int SEL_DONE  = 9;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       hit = 1'b0;
    logic       stand = 1'b0;
    logic [3:0] card_in;
    logic       card_valid;
    logic       card_ready;
    logic [4:0] tot_p, tot_d;
    logic [3:0] player_cnt, dealer_cnt;
    logic       player_turn, busy, player_bust, dealer_bust, round_done;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string name;
        int    sel;
        int    idx;
        int    exp;
    } exp_t;
    exp_t sb[$];
    int   src[$];
    bit   junk = 1'b0;

    SM_if sm();

    card_dealer #(.STOP_AT(17), .MAX_CARDS(9)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .hit                 (hit),
        .stand               (stand),
        .card_in             (card_in),
        .card_valid          (card_valid),
        .card_ready          (card_ready),
        .total_players_value (tot_p),
        .total_dealer_value  (tot_d),
        .card_if             (sm),
        .player_cnt          (player_cnt),
        .dealer_cnt          (dealer_cnt),
        .player_turn         (player_turn),
        .busy                (busy),
        .player_bust         (player_bust),
        .dealer_bust         (dealer_bust),
        .round_done          (round_done)
    );

    always #5 clk = ~clk;

    // Blackjack hand value: J/Q/K count 10, and one Ace counts 11 if that does not bust.
    function automatic int hand_total(input bit dealer);
        int sum = 0;
        bit ace = 1'b0;
        int v;
        for (int i = 0; i < 9; i++) begin
            v = dealer ? int'(sm.dealer_card_values[i]) : int'(sm.player_card_values[i]);
            if (v == 1) ace = 1'b1;
            sum += (v > 10) ? 10 : v;
        end
        if (ace && (sum + 10 <= 21)) sum += 10;
        return (sum > 31) ? 31 : sum;
    endfunction

    // Calculator model: totals are registered one edge after the slot write.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            tot_p <= 5'd0;
            tot_d <= 5'd0;
        end else begin
            tot_p <= 5'(hand_total(1'b0));
            tot_d <= 5'(hand_total(1'b1));
        end
    end

    // Card source: pop on a completed handshake, and present the next card at negedge.
    initial begin
        card_valid = 1'b0;
        card_in    = 4'd0;
        forever begin
            @(posedge clk);
            if (card_valid && card_ready && !junk && src.size() > 0) void'(src.pop_front());
            @(negedge clk);
            if (junk) begin
                card_valid = 1'b1;
                card_in    = 4'd15;
            end else if (src.size() > 0) begin
                card_valid = 1'b1;
                card_in    = 4'(src[0]);
            end else begin
                card_valid = 1'b0;
                card_in    = 4'd0;
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic int observe(input int sel, input int idx);
        case (sel)
            SEL_P:     return int'(sm.player_card_values[idx]);
            SEL_D:     return int'(sm.dealer_card_values[idx]);
            SEL_PCNT:  return int'(player_cnt);
            SEL_DCNT:  return int'(dealer_cnt);
            SEL_PBUST: return int'(player_bust);
            SEL_DBUST: return int'(dealer_bust);
            SEL_BUSY:  return int'(busy);
            SEL_READY: return int'(card_ready);
            SEL_TURN:  return int'(player_turn);
            default:   return int'(round_done);
        endcase
    endfunction

    task automatic want(input string name, input int sel, input int idx, input int exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.idx  = idx;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    // Queue all nine slots of one hand. Slots beyond the listed cards must read 0.
    task automatic want_hand(input string tag, input int sel, input int vals[$]);
        for (int i = 0; i < 9; i++) begin
            want($sformatf("%s[%0d]", tag, i), sel, i, (i < vals.size()) ? vals[i] : 0);
        end
    endtask

    task automatic drain(input string point);
        exp_t e;
        int   fails_before;
        int   checks_before;
        fails_before  = n_checks - n_pass;
        checks_before = n_checks;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.name, observe(e.sel, e.idx), e.exp);
        end
        $display("txn %-12s checks=%0d fails=%0d", point, n_checks - checks_before,
                 (n_checks - n_pass) - fails_before);
    endtask

    // Pulse one control input for a single cycle (0=start, 1=hit, 2=stand).
    task automatic pulse(input int which);
        if (which == 0) start = 1'b1;
        else if (which == 1) hit = 1'b1;
        else stand = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit   = 1'b0;
        stand = 1'b0;
    endtask

    task automatic wait_turn(input string tag, input int budget, output int cyc);
        cyc = 0;
        while (!player_turn && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        if (!player_turn) chk({tag, "_turn_timeout"}, 0, 1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int cyc;
        cyc = 0;
        while (!round_done && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        if (!round_done) chk({tag, "_done_timeout"}, 0, 1);
    endtask

    initial begin
        int cyc;
        int ace_q[$];

        // Reset state.
        repeat (2) @(negedge clk);
        want_hand("rst_p", SEL_P, '{});
        want_hand("rst_d", SEL_D, '{});
        want("rst_pcnt", SEL_PCNT, 0, 0);
        want("rst_busy", SEL_BUSY, 0, 0);
        want("rst_ready", SEL_READY, 0, 0);
        drain("reset");
        rst = 1'b1;
        @(negedge clk);

        // Opening deal 5,9,6,10. PLAYER is reached 5 cycles after start.
        src = '{5, 9, 6, 10};
        @(negedge clk);
        pulse(0);
        wait_turn("deal1", 20, cyc);
        chk("deal1_latency", cyc + 1, 5);
        want_hand("d1_p", SEL_P, '{5, 6});
        want_hand("d1_d", SEL_D, '{9, 10});
        want("d1_pcnt", SEL_PCNT, 0, 2);
        want("d1_dcnt", SEL_DCNT, 0, 2);
        want("d1_busy", SEL_BUSY, 0, 1);
        want("d1_ready", SEL_READY, 0, 0);
        drain("deal1");

        // A start pulse during PLAYER is ignored.
        pulse(0);
        repeat (2) @(negedge clk);
        want("ign_turn", SEL_TURN, 0, 1);
        want("ign_pcnt", SEL_PCNT, 0, 2);
        drain("start_ignored");

        // Stand with the dealer on 19: the dealer draws nothing and does not bust.
        pulse(2);
        wait_done("stand19", 10);
        want("s19_done", SEL_DONE, 0, 1);
        want("s19_dcnt", SEL_DCNT, 0, 2);
        want("s19_dbust", SEL_DBUST, 0, 0);
        want("s19_busy", SEL_BUSY, 0, 0);
        drain("stand19");
        @(negedge clk);
        want("s19_done_pulse", SEL_DONE, 0, 0);
        drain("done_pulse");

        // Deal 10,7,6,10, then hit with 8: the player busts on 24.
        src = '{10, 7, 6, 10};
        @(negedge clk);
        pulse(0);
        wait_turn("deal2", 20, cyc);
        src.push_back(8);
        pulse(1);
        wait_done("pbust", 20);
        want_hand("pb_p", SEL_P, '{10, 6, 8});
        want_hand("pb_d", SEL_D, '{7, 10});
        want("pb_pcnt", SEL_PCNT, 0, 3);
        want("pb_dcnt", SEL_DCNT, 0, 2);
        want("pb_pbust", SEL_PBUST, 0, 1);
        want("pb_dbust", SEL_DBUST, 0, 0);
        want("pb_done", SEL_DONE, 0, 1);
        drain("player_bust");

        // Deal 10,6,9,5, then stand: the dealer draws 4 (15) and then 7 (22), and busts.
        src = '{10, 6, 9, 5, 4, 7};
        @(negedge clk);
        pulse(0);
        wait_turn("deal3", 20, cyc);
        want("d3_pbust_clr", SEL_PBUST, 0, 0);
        drain("deal3");
        pulse(2);
        wait_done("dbust", 40);
        want_hand("db_p", SEL_P, '{10, 9});
        want_hand("db_d", SEL_D, '{6, 5, 4, 7});
        want("db_dcnt", SEL_DCNT, 0, 4);
        want("db_dbust", SEL_DBUST, 0, 1);
        want("db_pbust", SEL_PBUST, 0, 0);
        drain("dealer_bust");

        // Invalid codes during DEAL are consumed without any write.
        src = '{0, 14, 15, 2, 3, 4, 5};
        @(negedge clk);
        pulse(0);
        wait_turn("deal4", 30, cyc);
        want_hand("inv_p", SEL_P, '{2, 4});
        want_hand("inv_d", SEL_D, '{3, 5});
        want("inv_pcnt", SEL_PCNT, 0, 2);
        want("inv_dcnt", SEL_DCNT, 0, 2);
        drain("invalid_codes");

        // Seven Ace hits fill the hand to 9 cards without busting. The first hit is timed.
        src.push_back(1);
        @(negedge clk);
        pulse(1);
        wait_turn("hit1", 20, cyc);
        chk("hit_latency", cyc + 1, 4);
        for (int h = 0; h < 6; h++) begin
            src.push_back(1);
            pulse(1);
            wait_turn("hitn", 20, cyc);
        end
        ace_q = '{2, 4, 1, 1, 1, 1, 1, 1, 1};
        want_hand("full_p", SEL_P, ace_q);
        want("full_pcnt", SEL_PCNT, 0, 9);
        want("full_pbust", SEL_PBUST, 0, 0);
        drain("nine_cards");

        // A hit on a full hand goes to the dealer's turn.
        // The dealer is on 8 and the source is empty, so it stalls in D_DRAW.
        pulse(1);
        repeat (3) @(negedge clk);
        want("full_hit_pcnt", SEL_PCNT, 0, 9);
        want("full_hit_turn", SEL_TURN, 0, 0);
        want("ddraw_ready", SEL_READY, 0, 1);
        want("ddraw_busy", SEL_BUSY, 0, 1);
        drain("full_hit");

        // With junk codes held valid in D_DRAW, nothing changes.
        // An asynchronous reset then clears everything at once.
        junk = 1'b1;
        repeat (3) @(negedge clk);
        want("junk_dcnt", SEL_DCNT, 0, 2);
        want("junk_ready", SEL_READY, 0, 1);
        drain("junk_hold");
        #2;
        rst = 1'b0;
        #1;
        want_hand("arst_p", SEL_P, '{});
        want_hand("arst_d", SEL_D, '{});
        want("arst_pcnt", SEL_PCNT, 0, 0);
        want("arst_dcnt", SEL_DCNT, 0, 0);
        want("arst_busy", SEL_BUSY, 0, 0);
        want("arst_ready", SEL_READY, 0, 0);
        drain("async_reset");
        @(negedge clk);
        junk = 1'b0;
        rst  = 1'b1;
        @(negedge clk);
        pulse(1);
        repeat (2) @(negedge clk);
        want("idle_hit_busy", SEL_BUSY, 0, 0);
        want("idle_hit_turn", SEL_TURN, 0, 0);
        want("idle_hit_pcnt", SEL_PCNT, 0, 0);
        want("idle_hit_ready", SEL_READY, 0, 0);
        drain("idle_hit");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
